// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with a registered read port, occupancy count,
// programmable almost-full/almost-empty thresholds, sticky error flags and flush.
module sync_fifo_param #(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int AFULL_TH  = DEPTH - 4,
  parameter  int AEMPTY_TH = 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wa, ra;

  // Status flags depend on the count register alone, so they never glitch on requests.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AFULL_C);
    almost_empty = (count_q <= AEMPTY_C);
  end

  assign wa = wr_en & ~full & ~flush;
  assign ra = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wa) wr_ptr_d = wr_ptr_q + 1'b1;
      if (ra) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
        rd_valid_d = 1'b1;
      end
      if (wa && !ra)      count_d = count_q + 1'b1;
      else if (ra && !wa) count_d = count_q - 1'b1;
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; empty blocks any read of stale entries.
  always_ff @(posedge w_clk) begin
    if (wa) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO: the next generation of the team's 8x16 queue storage.
- Adds configurable width and depth, internal pointer management, count, programmable almost-full/almost-empty thresholds, and a registered read port with valid strobe.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Used as a same-domain buffer between producer and consumer stages.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=2.
- ADDR_W, log2(DEPTH), derived; not overridden.
- AFULL_TH, DEPTH-4, almost_full asserts when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1).

Ports:
- w_clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents/state.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  rd_data updated this cycle (1-cycle pulse per accepted read).
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Flags follow from count=0: empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- Pointers are ADDR_W+1 bits wide and wrap naturally. Entry index is ptr[ADDR_W-1:0]. count is a separate register kept consistent with the pointers.
- full, empty, almost_full and almost_empty are decoded combinationally from the count register only, never from wr_en/rd_en.
- Write accept (wa) = wr_en & ~full. On wa: mem[wr_ptr] <= wr_data and wr_ptr+1.
- Read accept (ra) = rd_en & ~empty. On ra: rd_data <= mem[rd_ptr], rd_ptr+1, rd_valid=1 in the following cycle.
- Read latency: 1 cycle from accepted rd_en to rd_data/rd_valid.
- When no read is accepted, rd_valid=0 and rd_data holds its last value.
- count update: +1 on wa&~ra; -1 on ra&~wa; unchanged on wa&ra or neither.
- Simultaneous wr_en and rd_en when full: the read is accepted and the write is rejected. count goes to DEPTH-1 and overflow is set.
- Simultaneous wr_en and rd_en when empty: the write is accepted and the read is rejected. count goes to 1 and underflow is set.
- There is no write-to-read bypass. Data written in cycle N is readable no earlier than cycle N+1.
- overflow is set on wr_en & full; underflow is set on rd_en & empty. Both remain set until rst or flush.
- flush (synchronous, highest priority after rst):
  - Next cycle: pointers=0, count=0, overflow=0, underflow=0, rd_valid=0.
  - rd_data is held.
  - Same-cycle wr_en/rd_en are ignored and do not set the error flags.
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers return to index 0 with no data corruption.
- Reset mid-operation: all state returns to reset values immediately. Stale memory contents are never observable, because empty=1 blocks reads.

Test Plan (DATA_W=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2):
- Reset, then write 0x01..0x10 with no reads.
  - After 3 writes: almost_empty=0.
  - After 12 writes: almost_full=1.
  - After 16 writes: full=1, count=16.
  - A 17th write (0xAA) sets overflow=1, count stays 16, and the data is discarded.
- From full, read 16 times.
  - rd_data=0x01..0x10 in order, each one cycle after rd_en, with rd_valid high each cycle.
  - Then empty=1.
  - One further rd_en sets underflow=1; rd_data holds 0x10 and rd_valid=0.
- Continuous simultaneous wr/rd: preload 5 entries, then run 40 cycles with wr_en=rd_en=1.
  - count stays 5 throughout.
  - Output sequence matches the input sequence; pointers wrap twice without error.
- Boundary simultaneity:
  - At count=16, wr_en=rd_en=1 gives count=15 and overflow=1.
  - At count=0, wr_en=rd_en=1 gives count=1, underflow=1 and rd_valid=0 next cycle.
- flush with 9 entries plus overflow set, asserted together with wr_en=1 and rd_en=1.
  - Next cycle: count=0, empty=1, overflow=0, rd_valid=0.
  - A subsequent write/read of 0x5C returns 0x5C.
- Assert rst asynchronously mid-burst, between clock edges, at count=7.
  - All outputs take reset values before the next edge.
  - After release, the FIFO operates normally from empty.
